// File: rtl/det_pkg.sv
// det_pkg: shared types, widths and helpers for the determinant sequencer
package det_pkg;
  localparam int ELEM_W = 8;
  localparam int MAX_N  = 5;
  localparam int ROW_W  = ELEM_W * MAX_N;
  localparam int MAT_W  = ROW_W * MAX_N;
  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_SETTLE, S_DONE} state_e;
  typedef enum logic [1:0] {SEL_DET2, SEL_DET3, SEL_DET4, SEL_DET5} det_sel_e;
  function automatic logic size_ok(input logic [2:0] s);
    return (s >= 3'd2) && (s <= 3'd5);
  endfunction
endpackage

// File: rtl/det_mat_reg.sv
// det_mat_reg: packed matrix register with whole-matrix clear and indexed row write
module det_mat_reg
  import det_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             wr_i,
  input  logic [2:0]       idx_i,
  input  logic [ROW_W-1:0] row_i,
  output logic [MAT_W-1:0] mat_o
);
  logic [MAT_W-1:0] mat_q;
  // row 0 occupies the top 40 bits; clear wins over a row write
  always_ff @(posedge clk or negedge rst)
    if (!rst) mat_q <= '0;
    else if (clr_i) mat_q <= '0;
    else if (wr_i)
      for (int r = 0; r < MAX_N; r++)
        if (idx_i == 3'(r)) mat_q[MAT_W-1-ROW_W*r -: ROW_W] <= row_i;
  assign mat_o = mat_q;
endmodule

// File: rtl/det_sched.sv
// det_sched: fetches N matrix rows, drives the det units, waits to settle and captures the result
module det_sched
  import det_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       size,
  output logic             busy,
  output logic             row_req,
  output logic [2:0]       row_idx,
  input  logic [ROW_W-1:0] row_data,
  input  logic             row_valid,
  output logic [MAT_W-1:0] mat_out,
  output logic [1:0]       det_sel,
  input  logic [ELEM_W-1:0] det_in,
  input  logic             ovf_in,
  output logic [ELEM_W-1:0] result,
  output logic             ovf,
  output logic             done,
  output logic             err
);
  state_e            state_q, state_d;
  logic [2:0]        n_q, idx_q;
  logic [1:0]        sel_q;
  logic [3:0]        cnt_q;
  logic [ELEM_W-1:0] res_q;
  logic              ovf_q, err_q;
  logic [ROW_W-1:0]  row_m;
  logic              accept, last_row;
  assign accept   = (state_q == S_IDLE) && start;
  assign last_row = idx_q == n_q - 3'd1;
  // state register
  always_ff @(posedge clk or negedge rst)
    if (!rst) state_q <= S_IDLE;
    else state_q <= state_d;
  // next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start) state_d = size_ok(size) ? S_FETCH : S_DONE;
      S_FETCH:  if (row_valid && last_row) state_d = S_SETTLE;
      S_SETTLE: if (cnt_q == 4'd0) state_d = S_DONE;
      default:  state_d = S_IDLE;
    endcase
  end
  // Moore outputs
  always_comb begin
    busy    = state_q != S_IDLE;
    row_req = state_q == S_FETCH;
    done    = state_q == S_DONE;
    err     = (state_q == S_DONE) && err_q;
  end
  // command latch, row index, settle counter and result capture
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      n_q   <= '0;
      idx_q <= '0;
      sel_q <= '0;
      cnt_q <= '0;
      res_q <= '0;
      ovf_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (start) begin
          if (size_ok(size)) begin
            n_q   <= size;
            sel_q <= 2'(size - 3'd2);
            idx_q <= '0;
            err_q <= 1'b0;
          end else begin
            err_q <= 1'b1;
            res_q <= '0;
            ovf_q <= 1'b0;
          end
        end
        S_FETCH: if (row_valid) begin
          if (last_row) cnt_q <= 4'(SETTLE_CYCLES - 1);
          else idx_q <= idx_q + 3'd1;
        end
        S_SETTLE: if (cnt_q == 4'd0) begin
          res_q <= det_in;
          ovf_q <= ovf_in;
        end else cnt_q <= cnt_q - 4'd1;
        default: err_q <= 1'b0;
      endcase
    end
  // columns at or beyond N are forced to zero regardless of the source
  always_comb begin
    row_m = '0;
    for (int c = 0; c < MAX_N; c++)
      row_m[ROW_W-1-ELEM_W*c -: ELEM_W] = (3'(c) < n_q) ? row_data[ROW_W-1-ELEM_W*c -: ELEM_W] : '0;
  end
  det_mat_reg u_mat (
    .clk   (clk),
    .rst   (rst),
    .clr_i (accept && size_ok(size)),
    .wr_i  ((state_q == S_FETCH) && row_valid),
    .idx_i (idx_q),
    .row_i (row_m),
    .mat_o (mat_out)
  );
  assign row_idx = idx_q;
  assign det_sel = sel_q;
  assign result  = res_q;
  assign ovf     = ovf_q;
endmodule

// File: tb/tb_det_sched.sv
// tb_det_sched: directed tests of the determinant sequencer with a behavioural det unit
module tb_det_sched;
  logic         clk = 1'b0;
  logic         rst, start, row_valid;
  logic [2:0]   size, row_idx;
  logic         busy, row_req, ovf_in, ovf, done, err;
  logic [39:0]  row_data;
  logic [199:0] mat_out;
  logic [1:0]   det_sel;
  logic [7:0]   det_in, result;
  logic [39:0]  rows_tb [5];
  int           dv;
  int           checks = 0;
  int           errors = 0;

  det_sched #(.SETTLE_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .start(start), .size(size), .busy(busy),
    .row_req(row_req), .row_idx(row_idx), .row_data(row_data), .row_valid(row_valid),
    .mat_out(mat_out), .det_sel(det_sel), .det_in(det_in), .ovf_in(ovf_in),
    .result(result), .ovf(ovf), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // Leibniz expansion over all index tuples, keeping only permutations
  function automatic int detf(input logic [199:0] m, input int n);
    int s, lim, t, prod, inv;
    int p [5];
    bit ok;
    logic signed [7:0] e;
    s = 0;
    lim = 1;
    for (int i = 0; i < n; i++) lim = lim * n;
    for (int k = 0; k < lim; k++) begin
      t = k; ok = 1; prod = 1; inv = 0;
      for (int i = 0; i < n; i++) begin p[i] = t % n; t = t / n; end
      for (int i = 0; i < n; i++)
        for (int j = i + 1; j < n; j++)
          if (p[i] == p[j]) ok = 0;
          else if (p[i] > p[j]) inv++;
      if (ok) begin
        for (int i = 0; i < n; i++) begin
          e = m[199-40*i-8*p[i] -: 8];
          prod = prod * int'(e);
        end
        s = (inv % 2 != 0) ? s - prod : s + prod;
      end
    end
    return s;
  endfunction

  always_comb begin
    dv = detf(mat_out, int'(det_sel) + 2);
    det_in = dv[7:0];
    ovf_in = (dv > 127) || (dv < -128);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic run_cmd(input logic [2:0] sz, input int dly, input bit poke,
                         output int edges, output bit err_d);
    int w;
    bit preq, pacc;
    logic [2:0] pidx;
    edges = -1; err_d = 0; w = 0; preq = 0; pacc = 0; pidx = '0;
    @(negedge clk); start = 1'b1; size = sz;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    for (int k = 0; k < 100; k++) begin
      if (dly > 0 && preq && !pacc) begin
        checks++;
        if (row_req !== 1'b1 || row_idx !== pidx) begin
          errors++;
          $display("FAIL row_hold: row_req=%b row_idx=%0d, want 1 and %0d", row_req, row_idx, pidx);
        end
      end
      if (done === 1'b1) begin
        edges = k; err_d = err; start = poke;
        @(posedge clk);
        @(negedge clk); start = 1'b0;
        break;
      end
      start = poke && busy && !row_req;
      preq = row_req; pidx = row_idx;
      if (row_req && w == dly) begin
        row_valid = 1'b1; row_data = rows_tb[row_idx]; w = 0;
      end else begin
        row_valid = 1'b0; w = row_req ? w + 1 : 0;
      end
      pacc = row_valid;
      @(posedge clk);
      @(negedge clk);
    end
    row_valid = 1'b0; start = 1'b0;
    if (edges < 0) begin
      checks++; errors++;
      $display("FAIL timeout: no done within 100 cycles");
    end
  endtask

  task automatic test_reset;
    rst = 1'b0; start = 1'b0; size = 3'd0; row_valid = 1'b0; row_data = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, row_req, row_idx, det_sel, result, ovf, done, err} !== 17'h0) begin
      errors++;
      $display("FAIL reset_outs: busy=%b req=%b idx=%0d sel=%0d res=%h ovf=%b done=%b err=%b, want all 0",
               busy, row_req, row_idx, det_sel, result, ovf, done, err);
    end
    checks++;
    if (mat_out !== 200'h0) begin errors++; $display("FAIL reset_mat: mat_out=%h, want 0", mat_out); end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    bit saw_done;
    rows_tb = '{40'h0101010101, 40'h0202020202, 40'h0, 40'h0, 40'h0};
    @(negedge clk); start = 1'b1; size = 3'd5;
    @(posedge clk);
    @(negedge clk); start = 1'b0; row_valid = 1'b1; row_data = rows_tb[0];
    @(posedge clk);
    @(negedge clk); row_data = rows_tb[1];
    @(posedge clk);
    @(negedge clk); row_valid = 1'b0;
    checks++;
    if (mat_out[199:120] !== {40'h0101010101, 40'h0202020202}) begin
      errors++; $display("FAIL mid_rows: mat_out=%h, want two rows loaded", mat_out);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({busy, row_req, row_idx, det_sel, result, ovf, done, err} !== 17'h0 || mat_out !== 200'h0) begin
      errors++;
      $display("FAIL mid_reset: busy=%b req=%b idx=%0d sel=%0d mat=%h, want all 0", busy, row_req, row_idx, det_sel, mat_out);
    end
    @(negedge clk); rst = 1'b1;
    saw_done = 0;
    repeat (6) begin
      @(negedge clk);
      if (done === 1'b1 || busy !== 1'b0) saw_done = 1;
    end
    checks++;
    if (saw_done) begin errors++; $display("FAIL mid_no_done: done or busy seen after abort, want none"); end
  endtask

  task automatic test_2x2;
    int e; bit er;
    rows_tb = '{40'h0301000000, 40'h0204000000, 40'h0, 40'h0, 40'h0};
    run_cmd(3'd2, 0, 0, e, er);
    checks++;
    if (e !== 4) begin errors++; $display("FAIL 2x2_latency: edges=%0d, want 4", e); end
    checks++;
    if (det_sel !== 2'd0) begin errors++; $display("FAIL 2x2_sel: det_sel=%0d, want 0", det_sel); end
    checks++;
    if (result !== 8'h0A || ovf !== 1'b0 || er !== 1'b0) begin
      errors++; $display("FAIL 2x2_result: result=%h ovf=%b err=%b, want 0a 0 0", result, ovf, er);
    end
  endtask

  task automatic test_5x5;
    int e; bit er;
    rows_tb = '{40'h0101010101, 40'h0101010001, 40'h0102010101, 40'h0000010101, 40'h0101000101};
    run_cmd(3'd5, 0, 0, e, er);
    checks++;
    if (e !== 7) begin errors++; $display("FAIL 5x5_latency: edges=%0d, want 7", e); end
    checks++;
    if (det_sel !== 2'd3) begin errors++; $display("FAIL 5x5_sel: det_sel=%0d, want 3", det_sel); end
    checks++;
    if (mat_out !== {40'h0101010101, 40'h0101010001, 40'h0102010101, 40'h0000010101, 40'h0101000101}) begin
      errors++; $display("FAIL 5x5_mat: mat_out=%h", mat_out);
    end
    checks++;
    if (result !== 8'hFF || ovf !== 1'b0 || er !== 1'b0) begin
      errors++; $display("FAIL 5x5_result: result=%h ovf=%b err=%b, want ff 0 0", result, ovf, er);
    end
  endtask

  task automatic test_3x3_wait;
    int e; bit er;
    rows_tb = '{40'h01FFFF0000, 40'h0001000000, 40'h0000010000, 40'h0, 40'h0};
    rows_tb[0] = 40'h0100000000;
    run_cmd(3'd3, 3, 0, e, er);
    checks++;
    if (e !== 14) begin errors++; $display("FAIL 3x3_latency: edges=%0d, want 14", e); end
    checks++;
    if (result !== 8'h01 || ovf !== 1'b0) begin
      errors++; $display("FAIL 3x3_result: result=%h ovf=%b, want 01 0", result, ovf);
    end
    checks++;
    if (mat_out !== {40'h0100000000, 40'h0001000000, 40'h0000010000, 80'h0}) begin
      errors++; $display("FAIL 3x3_mat: mat_out=%h", mat_out);
    end
  endtask

  task automatic test_col_mask;
    int e; bit er;
    rows_tb = '{40'h02000000FF, 40'h000300FF00, 40'h0, 40'h0, 40'h0};
    run_cmd(3'd2, 0, 0, e, er);
    checks++;
    if (mat_out !== {40'h0200000000, 40'h0003000000, 120'h0} || result !== 8'h06) begin
      errors++; $display("FAIL col_mask: mat_out=%h result=%h, want masked cols and 06", mat_out, result);
    end
  endtask

  task automatic test_ovf;
    int e; bit er;
    rows_tb = '{40'h6400000000, 40'h0064000000, 40'h0, 40'h0, 40'h0};
    run_cmd(3'd2, 0, 0, e, er);
    checks++;
    if (result !== 8'h10 || ovf !== 1'b1) begin
      errors++; $display("FAIL ovf: result=%h ovf=%b, want 10 1", result, ovf);
    end
  endtask

  task automatic test_size7;
    @(negedge clk); start = 1'b1; size = 3'd7;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    checks++;
    if (done !== 1'b1 || err !== 1'b1 || row_req !== 1'b0 || result !== 8'h00 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL size7_done: done=%b err=%b req=%b result=%h ovf=%b, want 1 1 0 00 0", done, err, row_req, result, ovf);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || err !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL size7_after: done=%b err=%b busy=%b, want 0 0 0", done, err, busy);
    end
  endtask

  task automatic test_busy_start;
    int e; bit er; bit extra;
    rows_tb = '{40'h0203000000, 40'h0105000000, 40'h0, 40'h0, 40'h0};
    run_cmd(3'd2, 0, 1, e, er);
    checks++;
    if (e !== 4 || result !== 8'h07) begin
      errors++; $display("FAIL busy_start_cmd: edges=%0d result=%h, want 4 07", e, result);
    end
    extra = 0;
    repeat (8) begin
      @(negedge clk);
      if (done === 1'b1 || busy !== 1'b0) extra = 1;
    end
    checks++;
    if (extra) begin errors++; $display("FAIL busy_start_queued: extra activity after done, want idle"); end
  endtask

  initial begin
    test_reset();
    test_reset_mid();
    test_2x2();
    test_5x5();
    test_3x3_wait();
    test_col_mask();
    test_ovf();
    test_size7();
    test_busy_start();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/det_sched.md
Name: det_sched

Overview:
- Sequencing controller for the shared combinational determinant datapath (det2..det5 units, 5x5 max, 8-bit signed elements, 8-bit det plus ovf).
- Accepts a determinant command from the coprocessor instruction decoder and fetches N matrix rows over a row handshake.
- Drives the packed 200-bit matrix bus and unit select, waits a fixed settle time, then captures det/ovf and returns it with a done pulse.

Parameters:
- SETTLE_CYCLES, 2, cycles the combinational det path is allowed to settle after the last row is loaded (legal range 1..15).
- ELEM_W, 8, element and result width in bits (fixed; other values unsupported).
- MAX_N, 5, maximum matrix order (fixed).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset asserted).
- start  in  1  command strobe, sampled only in IDLE.
- size  in  3  matrix order N; legal values 2..5.
- busy  out  1  high whenever state != IDLE.
- row_req  out  1  row fetch request, held until row_valid.
- row_idx  out  3  row being requested, 0..N-1.
- row_data  in  40  row elements; col c is at [39-8c -: 8], unused cols are zero.
- row_valid  in  1  row_data valid; accepted only while row_req=1.
- mat_out  out  200  matrix to the det units; row r is at [199-40r -: 40], cols above N-1 and rows above N-1 are zero.
- det_sel  out  2  unit select: 0=det2, 1=det3, 2=det4, 3=det5.
- det_in  in  8  signed determinant from the selected unit.
- ovf_in  in  1  overflow from the selected unit.
- result  out  8  captured signed determinant.
- ovf  out  1  captured overflow.
- done  out  1  one-cycle completion pulse.
- err  out  1  high with done for an illegal size.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, busy=0, row_req=0, row_idx=0, mat_out=0, det_sel=0, result=0, ovf=0, done=0, err=0, all counters 0. A reset mid-operation aborts the command; no done is produced.
- IDLE:
  - On start=1 with size in 2..5: latch N, set det_sel=N-2, clear mat_out to 0, row_idx=0, go to FETCH.
  - On start=1 with size in {0,1,6,7}: go to DONE with err=1, result=0, ovf=0. No row_req is issued.
- FETCH:
  - row_req=1 and row_idx is held stable until row_valid=1.
  - On the edge where row_valid=1: write row_data into row row_idx of mat_out.
  - If row_idx=N-1, go to SETTLE with the counter loaded to SETTLE_CYCLES-1; otherwise increment row_idx.
  - row_valid outside FETCH is ignored.
- SETTLE: mat_out and det_sel are held. Decrement the counter each cycle; at 0, capture det_in into result and ovf_in into ovf, then go to DONE.
- DONE: done=1 for exactly one cycle (err per the IDLE rule, otherwise 0), then go to IDLE. err returns to 0 with done.
- Latency: with zero-wait rows, done is high in the cycle after edge t0+N+SETTLE_CYCLES, where t0 is the start-accept edge. Example: N=5, S=2 gives done 7 edges after start.
- start while busy (including in the DONE cycle) is ignored and not queued.
- result/ovf hold until the next legal capture. An err command forces result/ovf to 0.
- mat_out/det_sel persist after DONE until the next accepted start.

Decomposition:
- Package det_pkg: state encoding (IDLE, FETCH, SETTLE, DONE), ROW_W=40, MAT_W=200, ELEM_W=8, det_sel codes, and a legal-size range function.
- One natural sub-module, det_mat_reg: the 200-bit matrix register with clear and indexed 40-bit row write. The FSM, settle counter and capture logic stay in det_sched.

Test Plan:
- Reset mid-FETCH (N=5, after 2 rows): assert rst=0 -> all outputs return to their reset values; no done; the next start works normally.
- 2x2 command with rows [3,1] and [2,4], real det units attached, S=2, zero-wait rows -> det_sel=0, done 4 edges after start, result=8'h0A, ovf=0, err=0.
- 5x5 command with rows 1_1_1_1_1 / 1_1_1_0_1 / 1_2_1_1_1 / 0_0_1_1_1 / 1_1_0_1_1 -> det_sel=3; mat_out equals the det5 packing; result=8'hFF (-1), ovf=0.
- 3x3 identity with row_valid delayed 3 cycles per row -> row_req and row_idx are held stable during the waits; done at 3+9+2 edges; result=1; mat_out rows 3..4 and cols 3..4 are zero.
- size=7 -> no row_req; done=1 and err=1 in the cycle after the start edge; result=0.
- start pulsed during SETTLE and during DONE -> ignored; exactly one done per accepted command.
